uart_code_lock_ctrl: RTL
========================

UART_CODE_LOCK_CTRL -- requirements
Module: uart_code_lock_ctrl

Interface
REQ-001 The block SHALL have a parameter CODE_LEN, default 4, giving the number of code bytes (1..4).
REQ-002 The block SHALL have a parameter CODE, default 32'h31323334 ("1234"), holding the code; the first expected byte is CODE[8*CODE_LEN-1 -: 8], MSB-first.
REQ-003 The block SHALL have a parameter OPEN_CYCLES, default 50_000_000, giving the auto-relock hold time in clk cycles.
REQ-004 The block SHALL have a parameter ENTRY_TIMEOUT, default 250_000_000, giving the maximum idle clk cycles between code bytes.
REQ-005 The block SHALL have a parameter LOCKOUT_CYCLES, default 500_000_000, giving the alarm/lockout duration in clk cycles.
REQ-006 The block SHALL have a parameter MAX_FAILS, default 3, giving the failed entries before lockout (1..15).
REQ-007 The block SHALL have the port clk, input, 1 bit: the single system clock; all logic is on its rising edge.
REQ-008 The block SHALL have the port rst, input, 1 bit: reset, synchronous and active-high.
REQ-009 The block SHALL have the port rx_valid, input, 1 bit: one-cycle strobe marking a received UART byte.
REQ-010 The block SHALL have the port rx_byte, input, 8 bits: received byte, valid only when rx_valid=1.
REQ-011 The block SHALL have the port lock_open, output, 1 bit: registered lock drive, 1 = open.
REQ-012 The block SHALL have the port alarm, output, 1 bit: registered, 1 while in LOCKOUT.
REQ-013 The block SHALL have the port fail_cnt, output, 4 bits: registered count of consecutive failed entries.

Function
REQ-014 The FSM SHALL have exactly four states: LOCKED, ENTRY, OPEN and LOCKOUT.
REQ-015 LOCKED: on rx_valid with rx_byte != 8'h2A ('*'), the block SHALL treat the byte as code byte 0, go to ENTRY and set idx=1 and mismatch=(byte!=expected[0]); '*' SHALL be ignored.
REQ-016 ENTRY: each rx_valid non-'*' byte SHALL be compared with expected[idx], OR-ing any miscompare into mismatch, then increment idx.
REQ-017 When the CODE_LEN-th byte is accepted with no mismatch, the FSM SHALL go to OPEN and clear fail_cnt; lock_open SHALL rise the cycle after that byte's rx_valid.
REQ-018 When the CODE_LEN-th byte is accepted with a mismatch, the FSM SHALL increment fail_cnt; if the new value equals MAX_FAILS it SHALL go to LOCKOUT, otherwise to LOCKED.
REQ-019 The block SHALL NOT reveal a mismatch before the full CODE_LEN bytes have been received.
REQ-020 ENTRY: rx_byte=8'h2A SHALL abort the entry to LOCKED with fail_cnt unchanged.
REQ-021 ENTRY: ENTRY_TIMEOUT cycles with no rx_valid SHALL abort the entry to LOCKED with fail_cnt unchanged; the idle counter SHALL restart on every accepted byte.
REQ-022 ENTRY: if rx_valid occurs on the timeout cycle, the byte SHALL win (accepted, counter restarted).
REQ-023 OPEN: lock_open=1 for exactly OPEN_CYCLES cycles, then return to LOCKED.
REQ-024 OPEN: rx_byte=8'h43 ('C') SHALL close the lock (lock_open=0 the next cycle) and go to LOCKED; all other bytes SHALL be ignored.
REQ-025 OPEN: if timer expiry and 'C' coincide, the result SHALL be a single close to LOCKED.
REQ-026 LOCKOUT: alarm=1 for exactly LOCKOUT_CYCLES cycles; all rx bytes SHALL be ignored; on exit fail_cnt SHALL be cleared and the FSM SHALL go to LOCKED.
REQ-027 The block SHALL use one shared down/up timer of at least 32 bits for the entry, open and lockout intervals, reloaded on each state entry; it SHALL never wrap.
REQ-028 lock_open SHALL be 1 only in OPEN, and alarm SHALL be 1 only in LOCKOUT; both SHALL never be 1 together.
REQ-029 The block SHALL contain no combinational path from its inputs to its outputs.

Reset
REQ-030 With rst=1 at a clk edge, the block SHALL set state=LOCKED, lock_open=0, alarm=0, fail_cnt=0, and clear idx, mismatch and timer, regardless of the current state (including mid-entry, OPEN and LOCKOUT).
REQ-031 While rst=1, rx_valid SHALL be ignored; operation SHALL resume on the first edge with rst=0.

Verification (CODE="1234", CODE_LEN=4, OPEN_CYCLES=100, ENTRY_TIMEOUT=50, LOCKOUT_CYCLES=200, MAX_FAILS=3)
REQ-032 Bytes 31,32,33,34 -> lock_open=1 one cycle after the 34 strobe, held exactly 100 cycles, then 0; fail_cnt=0.
REQ-033 Bytes 31,32,33,34 then 43 at cycle 10 of OPEN -> lock_open=0 the next cycle; state=LOCKED.
REQ-034 Three entries of 31,32,39,34 -> fail_cnt goes 1, 2, then alarm=1 for 200 cycles; a correct code sent during LOCKOUT is ignored; afterwards alarm=0 and fail_cnt=0.
REQ-035 Bytes 31,32, then 60 idle cycles, then 33,34 -> no open; the 33 starts a new entry; fail_cnt stays 0 until the entry completes.
REQ-036 Bytes 31,2A,31,32,33,34 -> the '*' aborts the first entry, the second entry opens the lock; fail_cnt=0.
REQ-037 rst=1 for one cycle during OPEN and again mid-entry -> outputs go to 0 the next cycle; a subsequent correct code opens normally.

Source files
------------

// File: rtl/uart_code_lock_ctrl.sv
// Code lock driven by UART bytes: collects CODE_LEN bytes, opens on a match,
// counts failed entries and raises a timed alarm/lockout after MAX_FAILS.
module uart_code_lock_ctrl #(
    parameter int          CODE_LEN       = 4,
    parameter logic [31:0] CODE           = 32'h31323334,
    parameter int          OPEN_CYCLES    = 50_000_000,
    parameter int          ENTRY_TIMEOUT  = 250_000_000,
    parameter int          LOCKOUT_CYCLES = 500_000_000,
    parameter int          MAX_FAILS      = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_valid,
    input  logic [7:0] rx_byte,
    output logic       lock_open,
    output logic       alarm,
    output logic [3:0] fail_cnt
);

    // rx_valid is a one-cycle strobe with no backpressure: rx_byte is only
    // meaningful while rx_valid=1, and every strobe is consumed on that edge.

    localparam logic [1:0] LOCKED  = 2'd0;
    localparam logic [1:0] ENTRY   = 2'd1;
    localparam logic [1:0] OPEN    = 2'd2;
    localparam logic [1:0] LOCKOUT = 2'd3;

    localparam logic [7:0] ABORT_BYTE = 8'h2A;
    localparam logic [7:0] CLOSE_BYTE = 8'h43;

    // Code left-aligned so the first expected byte always sits in [31:24].
    localparam logic [31:0] CODE_ALIGNED = CODE << (8 * (4 - CODE_LEN));
    localparam logic [1:0]  LAST_IDX     = 2'(CODE_LEN - 1);
    localparam logic [3:0]  FAIL_LIMIT   = 4'(MAX_FAILS);

    localparam logic [31:0] OPEN_LOAD    = 32'(OPEN_CYCLES - 1);
    localparam logic [31:0] ENTRY_LOAD   = 32'(ENTRY_TIMEOUT - 1);
    localparam logic [31:0] LOCKOUT_LOAD = 32'(LOCKOUT_CYCLES - 1);

    logic [1:0]  state;
    logic [1:0]  state_n;
    logic [1:0]  idx;
    logic [1:0]  idx_n;
    logic        mismatch;
    logic        mismatch_n;
    logic [31:0] timer;
    logic [31:0] timer_n;
    logic [3:0]  fail_n;

    logic        byte_in;
    logic        abort_in;
    logic        close_in;
    logic        expired;
    logic [1:0]  byte_idx;
    logic [7:0]  exp_byte;
    logic        miss_acc;
    logic        last_byte;
    logic [3:0]  fail_inc;

    always_comb begin
        byte_in  = rx_valid && (rx_byte != ABORT_BYTE);
        abort_in = rx_valid && (rx_byte == ABORT_BYTE);
        close_in = rx_valid && (rx_byte == CLOSE_BYTE);
        expired  = (timer == 32'd0);
        // A byte arriving in LOCKED is always code byte 0.
        byte_idx = (state == ENTRY) ? idx : 2'd0;
        case (byte_idx)
            2'd0:    exp_byte = CODE_ALIGNED[31:24];
            2'd1:    exp_byte = CODE_ALIGNED[23:16];
            2'd2:    exp_byte = CODE_ALIGNED[15:8];
            default: exp_byte = CODE_ALIGNED[7:0];
        endcase
        miss_acc  = ((state == ENTRY) && mismatch) || (rx_byte != exp_byte);
        last_byte = (byte_idx == LAST_IDX);
        fail_inc  = fail_cnt + 4'd1;
    end

    always_comb begin
        state_n    = state;
        idx_n      = idx;
        mismatch_n = mismatch;
        timer_n    = timer;
        fail_n     = fail_cnt;
        case (state)
            LOCKED, ENTRY: begin
                if (byte_in) begin
                    if (last_byte) begin
                        // Verdict only once the full code length is in.
                        idx_n      = 2'd0;
                        mismatch_n = 1'b0;
                        if (!miss_acc) begin
                            state_n = OPEN;
                            timer_n = OPEN_LOAD;
                            fail_n  = 4'd0;
                        end else if (fail_inc == FAIL_LIMIT) begin
                            state_n = LOCKOUT;
                            timer_n = LOCKOUT_LOAD;
                            fail_n  = fail_inc;
                        end else begin
                            state_n = LOCKED;
                            timer_n = 32'd0;
                            fail_n  = fail_inc;
                        end
                    end else begin
                        state_n    = ENTRY;
                        idx_n      = byte_idx + 2'd1;
                        mismatch_n = miss_acc;
                        timer_n    = ENTRY_LOAD;
                    end
                end else if ((state == ENTRY) && (abort_in || expired)) begin
                    state_n    = LOCKED;
                    idx_n      = 2'd0;
                    mismatch_n = 1'b0;
                    timer_n    = 32'd0;
                end else if (state == ENTRY) begin
                    timer_n = timer - 32'd1;
                end
            end
            OPEN: begin
                // Expiry and a close byte together still mean one close.
                if (close_in || expired) begin
                    state_n = LOCKED;
                    timer_n = 32'd0;
                end else begin
                    timer_n = timer - 32'd1;
                end
            end
            LOCKOUT: begin
                if (expired) begin
                    state_n = LOCKED;
                    fail_n  = 4'd0;
                end else begin
                    timer_n = timer - 32'd1;
                end
            end
            default: begin
                state_n    = LOCKED;
                idx_n      = 2'd0;
                mismatch_n = 1'b0;
                timer_n    = 32'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= LOCKED;
            idx       <= 2'd0;
            mismatch  <= 1'b0;
            timer     <= 32'd0;
            fail_cnt  <= 4'd0;
            lock_open <= 1'b0;
            alarm     <= 1'b0;
        end else begin
            state     <= state_n;
            idx       <= idx_n;
            mismatch  <= mismatch_n;
            timer     <= timer_n;
            fail_cnt  <= fail_n;
            // Outputs decoded from the next state so they change with it.
            lock_open <= (state_n == OPEN);
            alarm     <= (state_n == LOCKOUT);
        end
    end

endmodule
